seq_div: RTL

- Iterative radix-2 restoring divider: 32-bit dividend / 16-bit divisor -> 32-bit quotient, 16-bit remainder.
- It is the inverse path of the registered 16x16 multiplier. It recovers a factor from a 32-bit product and feeds fixed-point normalisation in the datapath.
- Uses a start/busy/done handshake; one iteration per clock.

---
 rtl/seq_div_if.sv | 25 ++
 rtl/seq_div.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seq_div_if.sv
// seq_div_if: start/busy/done handshake plus operand and result bus for seq_div.
// The divider connects through the slave modport, the requester through master.
interface seq_div_if #(
    parameter int DW = 32,
    parameter int VW = 16
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div.sv
// seq_div: iterative radix-2 restoring divider, DW-bit dividend / VW-bit divisor, one bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division); default is unsigned.
module seq_div #(
    parameter int DW = 32,
    parameter int VW = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_div_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ZERO = 2'd3;

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [VW:0]   prem;
    logic [DW-1:0] quo_r;
    logic [VW-1:0] rem_r;
    logic          dbz_r;

    logic          accept;
    logic          zero_div;
    logic [DW-1:0] op_a;
    logic [VW-1:0] op_b;
    logic [VW:0]   p_sh;
    logic [VW:0]   p_nxt;
    logic          qbit;
    logic [DW-1:0] q_raw;
    logic [DW-1:0] q_fin;
    logic [VW-1:0] r_fin;

`ifdef SEQ_DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;
`endif

    assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign zero_div = (bus.divisor == '0);

    always_comb begin
        op_a = bus.dividend;
        op_b = bus.divisor;
`ifdef SEQ_DIV_SIGNED_EN
        if (bus.dividend[DW-1]) op_a = -bus.dividend;
        if (bus.divisor[VW-1])  op_b = -bus.divisor;
`endif
    end

    // P never exceeds the divisor after an iteration, so its top bit can be dropped on the shift
    always_comb begin
        p_sh  = {prem[VW-1:0], dvd[DW-1]};
        qbit  = (p_sh >= {1'b0, dvs});
        p_nxt = qbit ? (p_sh - {1'b0, dvs}) : p_sh;
        q_raw = {dvd[DW-2:0], qbit};
        q_fin = q_raw;
        r_fin = p_nxt[VW-1:0];
`ifdef SEQ_DIV_SIGNED_EN
        if (q_neg) q_fin = -q_raw;
        if (r_neg) r_fin = -p_nxt[VW-1:0];
`endif
    end

    // dvd shifts the dividend out of the top while quotient bits fill from the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            prem  <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dbz_r <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            q_neg <= 1'b0;
            r_neg <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dvd   <= zero_div ? bus.dividend : op_a;
                        dvs   <= op_b;
                        prem  <= '0;
                        cnt   <= '0;
                        state <= zero_div ? S_ZERO : S_RUN;
`ifdef SEQ_DIV_SIGNED_EN
                        q_neg <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                        r_neg <= bus.dividend[DW-1];
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    dvd  <= q_raw;
                    prem <= p_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        quo_r <= q_fin;
                        rem_r <= r_fin;
                        dbz_r <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: begin
                    quo_r <= '1;
                    rem_r <= dvd[VW-1:0];
                    dbz_r <= 1'b1;
                    state <= S_DONE;
                end
            endcase
        end
    end

    assign bus.busy        = (state == S_RUN);
    assign bus.done        = (state == S_DONE);
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule
